alu_op_sequencer: RTL and testbench

- Initiator-side controller for the team's registered 32-bit ALU. The ALU latches its result on the CLK rising edge and decodes opcodes 000 add, 001 and, 010 or, 011 mul, 100 sub, 101 unsigned less-than; any other opcode yields 0.
- Accepts operation commands over a valid/ready handshake and drives the ALU operand/opcode bus.
- Waits out the ALU's one-cycle registered latency, then captures the result. Returns result, zero and illegal flags over a valid/ready response channel.
- Supports chaining, where the previous result is used as operand A.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_op_sequencer.sv | 138 +++++++++++++
 tb/tb_alu_op_sequencer.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcode constants, legality check and sequencer state
//               encoding for the registered 32-bit ALU and its initiator.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // ALU opcodes; 110 and 111 are undefined and produce 0 in the ALU
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;

    // Sequencer states: one issue cycle, one capture cycle, then the response
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    // Every opcode up to and including SLT is defined by the ALU
    function automatic logic is_legal_op(input logic [2:0] op);
        return (op <= OP_SLT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_sequencer
// Description : Initiator-side controller for the registered ALU. Accepts a
//               command, drives the operand bus, waits out the ALU's one-cycle
//               latency, captures the result and returns it with zero and
//               illegal flags. Supports chaining the previous result into A.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int COUNT_W = 16
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_op,
    input  logic [DATA_W-1:0]  cmd_a,
    input  logic [DATA_W-1:0]  cmd_b,
    input  logic               cmd_chain,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [2:0]         alu_sel,
    input  logic [DATA_W-1:0]  alu_r,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_result,
    output logic               rsp_zero,
    output logic               rsp_illegal,
    output logic               busy,
    output logic [COUNT_W-1:0] op_count
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_illegal;
    logic [DATA_W-1:0]   r_last_result;
    logic [DATA_W-1:0]   w_capt_val;
    logic                w_accept;
    logic                w_capture;
    logic                w_consume;

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus handshake strobes derived from the current state
    always_comb begin
        w_state_nxt = r_state;
        cmd_ready   = 1'b0;
        busy        = 1'b1;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_consume   = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                w_state_nxt = CAPTURE;
            end
            CAPTURE: begin
                w_capture   = 1'b1;
                w_state_nxt = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    w_consume   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // An illegal opcode still runs through the ALU, but its output is discarded
    assign w_capt_val = r_illegal ? '0 : alu_r;

    // Operand bus: loaded on accept, held at the last issued values otherwise
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= OP_ADD;
            r_illegal <= 1'b0;
        end else if (w_accept) begin
            alu_a     <= cmd_chain ? r_last_result : cmd_a;
            alu_b     <= cmd_b;
            alu_sel   <= cmd_op;
            r_illegal <= !is_legal_op(cmd_op);
        end
    end

    // Response channel: captured once, held until consumed
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rsp_result    <= '0;
            r_last_result <= '0;
            rsp_zero      <= 1'b0;
            rsp_illegal   <= 1'b0;
            rsp_valid     <= 1'b0;
        end else if (w_capture) begin
            rsp_result    <= w_capt_val;
            r_last_result <= w_capt_val;
            rsp_zero      <= (w_capt_val == '0);
            rsp_illegal   <= r_illegal;
            rsp_valid     <= 1'b1;
        end else if (w_consume) begin
            rsp_valid     <= 1'b0;
        end
    end

    // Completed-operation counter, wraps naturally at its width
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            op_count <= '0;
        end else if (w_consume) begin
            op_count <= op_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_op_sequencer
// Description : Scoreboard bench for alu_op_sequencer with a behavioural
//               registered ALU behind the operand bus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = 3'd0;
    logic [DW-1:0] cmd_a = '0;
    logic [DW-1:0] cmd_b = '0;
    logic          cmd_chain = 1'b0;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [2:0]    alu_sel;
    logic [DW-1:0] alu_r;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_result;
    logic          rsp_zero;
    logic          rsp_illegal;
    logic          busy;
    logic [CW-1:0] op_count;

    logic          rnd_bp = 1'b0;
    logic          rnd_bit = 1'b1;
    logic          rsp_ready_dir = 1'b1;
    assign rsp_ready = rnd_bp ? rnd_bit : rsp_ready_dir;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct {
        logic [DW-1:0] res;
        logic          zero;
        logic          ill;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [2:0]    op;
        int            acc;
    } exp_t;

    exp_t          q[$];
    logic [DW-1:0] model_last = '0;
    int            exp_cnt = 0;
    logic          prev_valid = 1'b0;

    alu_op_sequencer #(.DATA_W(DW), .COUNT_W(CW)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_r(alu_r),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal),
        .busy(busy), .op_count(op_count)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;
    always @(negedge CLK) rnd_bit = ($urandom_range(0, 2) != 0);

    // Registered ALU sitting behind the sequencer
    always @(posedge CLK) begin
        case (alu_sel)
            3'b000:  alu_r <= alu_a + alu_b;
            3'b001:  alu_r <= alu_a & alu_b;
            3'b010:  alu_r <= alu_a | alu_b;
            3'b011:  alu_r <= alu_a * alu_b;
            3'b100:  alu_r <= alu_a - alu_b;
            3'b101:  alu_r <= (alu_a < alu_b) ? 32'd1 : 32'd0;
            default: alu_r <= '0;
        endcase
    end

    // Expected result from plain 64-bit arithmetic reduced modulo 2^32
    function automatic logic [DW-1:0] ref_op(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        longint unsigned m  = 64'h1_0000_0000;
        longint unsigned la = 64'(a);
        longint unsigned lb = 64'(b);
        longint unsigned r;
        case (op)
            3'd0:    r = (la + lb) % m;
            3'd1:    r = la & lb;
            3'd2:    r = la | lb;
            3'd3:    r = (la * lb) % m;
            3'd4:    r = (la + m - lb) % m;
            3'd5:    r = (la < lb) ? 64'd1 : 64'd0;
            default: r = 64'd0;
        endcase
        return r[DW-1:0];
    endfunction

    task automatic chk(input string name, input longint unsigned got, input longint unsigned exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever a response is handed over
    always begin
        exp_t e;
        @(negedge CLK);
        #2;
        if (!RST_N) begin
            q.delete();
            exp_cnt    = 0;
            prev_valid = 1'b0;
        end else begin
            if (rsp_valid && !prev_valid) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rsp got=%0h exp=none t=%0t", rsp_result, $time);
                end else begin
                    chk("latency", longint'(cyc - q[0].acc), 64'd2);
                end
            end
            if (rsp_valid && rsp_ready && q.size() > 0) begin
                e = q.pop_front();
                chk("result",   rsp_result,  e.res);
                chk("zero",     rsp_zero,    e.zero);
                chk("illegal",  rsp_illegal, e.ill);
                chk("alu_a",    alu_a,       e.a);
                chk("alu_b",    alu_b,       e.b);
                chk("alu_sel",  alu_sel,     e.op);
                chk("op_count", op_count,    longint'(exp_cnt));
                exp_cnt = (exp_cnt + 1) % (1 << CW);
            end
            prev_valid = rsp_valid;
        end
    end

    // Offer one command and record its expected response on acceptance
    task automatic send(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic ch);
        int n;
        exp_t e;
        logic [DW-1:0] ae;
        @(negedge CLK);
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_chain = ch; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (!cmd_ready) begin
            chk("send_timeout", 64'd1, 64'd0);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge CLK);
        #1;
        cmd_valid = 1'b0;
        ae     = ch ? model_last : a;
        e.op   = op;
        e.a    = ae;
        e.b    = b;
        e.ill  = (op >= 3'd6);
        e.res  = e.ill ? '0 : ref_op(op, ae, b);
        e.zero = (e.res == '0);
        e.acc  = cyc;
        model_last = e.res;
        q.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge CLK);
            n++;
        end
        chk("drain", longint'(q.size()), 64'd0);
        @(negedge CLK);
    endtask

    initial begin
        logic [DW+2:0] snap;
        logic [CW-1:0] cnt_before;

        // Reset state
        repeat (3) @(negedge CLK);
        #1;
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_sel", alu_sel, 0);
        chk("rst_result", rsp_result, 0);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_zero", rsp_zero, 0);
        chk("rst_illegal", rsp_illegal, 0);
        chk("rst_count", op_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        #2 RST_N = 1'b1;

        // Directed operations
        send(3'b000, 32'd5, 32'd7, 1'b0);
        drain();
        chk("count_after_add", op_count, 1);
        send(3'b100, 32'd9, 32'd9, 1'b0);
        send(3'b000, 32'h0000_FFFF, 32'd3, 1'b1);
        send(3'b011, 32'h0001_0000, 32'h0001_0000, 1'b0);
        send(3'b101, 32'd1, 32'hFFFF_FFFF, 1'b0);
        send(3'b111, 32'd3, 32'd4, 1'b0);
        send(3'b000, 32'h1234_5678, 32'd2, 1'b1);
        drain();

        // Backpressure: response held, competing command ignored
        rsp_ready_dir = 1'b0;
        send(3'b010, 32'h00F0, 32'h000F, 1'b0);
        begin
            int n = 0;
            while (!rsp_valid && n < 20) begin
                @(negedge CLK);
                n++;
            end
        end
        chk("bp_valid", rsp_valid, 1);
        snap = {rsp_valid, rsp_zero, rsp_illegal, rsp_result};
        cmd_op = 3'b000; cmd_a = 32'hDEAD; cmd_b = 32'h1; cmd_chain = 1'b0; cmd_valid = 1'b1;
        repeat (5) begin
            @(negedge CLK);
            #1;
            chk("bp_stable", {rsp_valid, rsp_zero, rsp_illegal, rsp_result}, snap);
            chk("bp_cmd_ready", cmd_ready, 0);
        end
        @(negedge CLK);
        cmd_valid = 1'b0;
        rsp_ready_dir = 1'b1;
        cnt_before = op_count;
        @(negedge CLK);
        #1;
        chk("bp_count_inc", op_count, CW'(cnt_before + 1'b1));
        chk("bp_cmd_ready_back", cmd_ready, 1);
        chk("bp_valid_low", rsp_valid, 0);
        drain();

        // Reset while in CAPTURE, then chain from the cleared result
        send(3'b000, 32'd40, 32'd2, 1'b0);
        @(posedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_count", op_count, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_alu_a", alu_a, 0);
        model_last = '0;
        @(negedge CLK);
        @(negedge CLK);
        #3 RST_N = 1'b1;
        repeat (3) @(negedge CLK);
        #1;
        chk("post_rst_valid", rsp_valid, 0);
        chk("post_rst_busy", busy, 0);
        send(3'b000, 32'h55, 32'd6, 1'b1);
        drain();

        // Randomized traffic with random response backpressure; wraps op_count
        rnd_bp = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [2:0]    op;
            logic [DW-1:0] a;
            logic [DW-1:0] b;
            op = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : 32'($urandom());
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : 32'($urandom());
            send(op, a, b, ($urandom_range(0, 2) == 0));
        end
        @(negedge CLK);
        rnd_bp = 1'b0;
        drain();
        chk("final_count", op_count, longint'(exp_cnt));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
